// File: rtl/load_store_unit_pkg.sv
// Shared core types for the load/store unit: opcodes, access sizes, LSU FSM states
// and small decode helpers for funct3 and alignment.
package load_store_unit_pkg;

    localparam int RISC_V_DATA_WIDTH = 32;
    localparam int INSTR_WIDTH       = 32;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_OP     = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    // 011 and 11x have no defined size; they fall through to a full word.
    function automatic mem_size_t decode_size(input logic [2:0] funct3);
        if (funct3[1])
            return WORD;
        else if (funct3[0])
            return HALF;
        else
            return BYTE;
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
        case (size)
            HALF:    return offset[0];
            WORD:    return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_data_align.sv
// Byte-lane steering for the LSU: store byte enables and data placement, and
// load data extraction with sign or zero extension.
module lsu_data_align
    import load_store_unit_pkg::*;
(
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Lanes pushed beyond byte 3 by a misaligned offset simply fall off.
    always_comb begin
        be = 4'b1111;
        case (size)
            BYTE:    be = 4'(4'b0001 << offset);
            HALF:    be = 4'(4'b0011 << offset);
            default: be = 4'b1111;
        endcase
    end

    assign wdata   = rs2 << {offset, 3'b000};
    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        load_data = shifted;
        case (size)
            BYTE:    load_data = {{24{shifted[7]  & ~is_unsigned}}, shifted[7:0]};
            HALF:    load_data = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RISC-V load/store unit with req/gnt/rvalid memory handshake.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = RISC_V_DATA_WIDTH,
    parameter int DATA_WIDTH = RISC_V_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  opcode_t               in_opcode,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_rs1,
    input  logic [DATA_WIDTH-1:0] in_rs2,
    input  logic [DATA_WIDTH-1:0] in_offset,
    input  logic [4:0]            in_rd,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
`ifdef LSU_MISALIGN_CHECK_EN
    output logic                  misalign_err,
    output logic [ADDR_WIDTH-1:0] misalign_addr,
`endif
    output logic                  st_done
);

    lsu_state_t            state_reg, state_next;
    logic [DATA_WIDTH-1:0] ea;
    logic [DATA_WIDTH-1:0] ea_reg;
    logic [DATA_WIDTH-1:0] rs2_reg;
    mem_size_t             size_reg;
    logic                  unsigned_reg;
    logic                  we_reg;
    logic [4:0]            rd_reg;
    logic                  wb_valid_reg;
    logic [4:0]            wb_rd_reg;
    logic [DATA_WIDTH-1:0] wb_data_reg;
    logic                  st_done_reg;
    logic                  accept;
    logic                  misaligned;
    logic                  load_done;
    logic                  store_done;
    logic [3:0]            align_be;
    logic [DATA_WIDTH-1:0] align_wdata;
    logic [DATA_WIDTH-1:0] align_load;

    assign ea         = in_rs1 + in_offset;
    assign accept     = in_valid && (state_reg == IDLE) &&
                        (in_opcode == OP_LOAD || in_opcode == OP_STORE);
    assign load_done  = (state_reg == WAIT) && mem_rvalid;
    assign store_done = (state_reg == REQ) && mem_gnt && we_reg;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(decode_size(in_funct3), ea[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && !misaligned) state_next = REQ;
            REQ:     if (mem_gnt) state_next = we_reg ? IDLE : WAIT;
            WAIT:    if (mem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ea_reg       <= '0;
            rs2_reg      <= '0;
            size_reg     <= BYTE;
            unsigned_reg <= 1'b0;
            we_reg       <= 1'b0;
            rd_reg       <= '0;
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
            st_done_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wb_valid_reg <= load_done;
            st_done_reg  <= store_done;
            if (accept) begin
                ea_reg       <= ea;
                rs2_reg      <= in_rs2;
                size_reg     <= decode_size(in_funct3);
                unsigned_reg <= in_funct3[2];
                we_reg       <= (in_opcode == OP_STORE);
                rd_reg       <= in_rd;
            end
            if (load_done) begin
                wb_rd_reg   <= rd_reg;
                wb_data_reg <= align_load;
            end
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic                  misalign_err_reg;
    logic [ADDR_WIDTH-1:0] misalign_addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err_reg  <= 1'b0;
            misalign_addr_reg <= '0;
        end else begin
            misalign_err_reg <= accept && misaligned;
            if (accept && misaligned)
                misalign_addr_reg <= ea[ADDR_WIDTH-1:0];
        end
    end

    assign misalign_err  = misalign_err_reg;
    assign misalign_addr = misalign_addr_reg;
`endif

    lsu_data_align u_align (
        .size        (size_reg),
        .is_unsigned (unsigned_reg),
        .offset      (ea_reg[1:0]),
        .rs2         (rs2_reg),
        .rdata       (mem_rdata),
        .be          (align_be),
        .wdata       (align_wdata),
        .load_data   (align_load)
    );

    // Memory-side outputs derive only from latched state, so they hold steady until grant.
    assign in_ready  = (state_reg == IDLE);
    assign mem_req   = (state_reg == REQ);
    assign mem_we    = mem_req && we_reg;
    assign mem_addr  = {ea_reg[ADDR_WIDTH-1:2], 2'b00};
    assign mem_be    = mem_req ? align_be : 4'b0000;
    assign mem_wdata = mem_we ? align_wdata : '0;
    assign wb_valid  = wb_valid_reg;
    assign wb_rd     = wb_rd_reg;
    assign wb_data   = wb_data_reg;
    assign st_done   = st_done_reg;

endmodule
